// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, word type, and the memory
// controller FSM encoding plus its error-load constant.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DREQ = 2'd1,
    IREQ = 2'd2
  } memctl_state_t;

  localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/memory_control.sv
// Arbitrates instruction fetches and data accesses onto a single-port,
// variable-latency RAM; a watchdog forces completion on RAM error or stall.
module memory_control
  import cpu_types_pkg::*;
#(
  parameter int                WORD_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [WORD_W-1:0] BAD_WORD = cpu_types_pkg::BAD_WORD
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              merr,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  memctl_state_t     state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              merr_reg, merr_next;
  logic [WORD_W-1:0] addr_reg, addr_next;
  logic [WORD_W-1:0] store_reg, store_next;
  logic              write_reg, write_next;

  ramstate_t         rs;
  logic              ram_ok;
  logic              ram_err;
  logic [WORD_W-1:0] load_val;

  assign rs       = ramstate_t'(ramstate);
  assign ram_ok   = (rs == ACCESS);
  // Timeout fires on the last allowed wait cycle so the hit lands TIMEOUT cycles after the grant.
  assign ram_err  = (rs == ERROR) || ((cnt_reg == CNT_LAST) && !ram_ok);
  assign load_val = ram_err ? BAD_WORD : ramload;

  assign merr = merr_reg;
  assign busy = (state_reg != IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      merr_reg  <= 1'b0;
      addr_reg  <= '0;
      store_reg <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      merr_reg  <= merr_next;
      addr_reg  <= addr_next;
      store_reg <= store_next;
      write_reg <= write_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    merr_next  = merr_reg;
    addr_next  = addr_reg;
    store_next = store_reg;
    write_next = write_reg;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    ihit       = 1'b0;
    dhit       = 1'b0;
    iload      = '0;
    dload      = '0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        // Data side wins; a simultaneous read+write is treated as a write.
        if (dREN || dWEN) begin
          addr_next  = daddr;
          store_next = dstore;
          write_next = dWEN;
          state_next = DREQ;
        end else if (iREN) begin
          addr_next  = iaddr;
          store_next = '0;
          write_next = 1'b0;
          state_next = IREQ;
        end
      end

      DREQ, IREQ: begin
        ramaddr  = addr_reg;
        ramstore = store_reg;
        ramWEN   = (state_reg == DREQ) && write_reg;
        ramREN   = (state_reg == IREQ) || ((state_reg == DREQ) && !write_reg);
        if (ram_ok || ram_err) begin
          if (state_reg == DREQ) begin
            dhit  = 1'b1;
            dload = load_val;
          end else begin
            ihit  = 1'b1;
            iload = load_val;
          end
          if (ram_err) merr_next = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_control.sv
// Directed self-checking bench for memory_control: fetch, contention, write,
// timeout, RAM error and asynchronous reset mid-transaction.
module tb_memory_control;

  localparam int TIMEOUT = 255;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, merr, busy;

  int total = 0;
  int bad   = 0;

  memory_control #(.WORD_W(32), .TIMEOUT(TIMEOUT), .BAD_WORD(BAD)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .merr(merr), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = S_FREE;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_merr", 32'(merr), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_hits", 32'({ihit, dhit}), 0);
    @(negedge CLK) nRST = 1'b1;
    tick();
    $display("reset released");

    // Instruction fetch with 3 BUSY cycles
    iREN = 1; iaddr = 32'h40; #1;
    chk("if_grant_busy", 32'(busy), 0);
    chk("if_grant_ren", 32'(ramREN), 0);
    tick();
    ramstate = S_BUSY;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("if_wait_ren", 32'(ramREN), 1);
      chk("if_wait_addr", ramaddr, 32'h40);
      chk("if_wait_hit", 32'(ihit), 0);
      tick();
    end
    ramstate = S_ACCESS; ramload = 32'h8C220004; #1;
    chk("if_hit", 32'(ihit), 1);
    chk("if_load", iload, 32'h8C220004);
    chk("if_hit_ren", 32'(ramREN), 1);
    chk("if_merr", 32'(merr), 0);
    $display("fetch 0x40 -> ihit=%0b iload=%h", ihit, iload);
    iREN = 0;
    tick();
    ramstate = S_FREE; #1;
    chk("if_after_busy", 32'(busy), 0);
    chk("if_after_hit", 32'(ihit), 0);
    chk("if_after_load", iload, 0);

    // Contention: data wins, one bubble, then fetch
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; #1;
    tick();
    ramstate = S_ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("ct_dhit", 32'(dhit), 1);
    chk("ct_ihit_lo", 32'(ihit), 0);
    chk("ct_dload", dload, 32'hDEADBEEF);
    chk("ct_daddr", ramaddr, 32'h100);
    chk("ct_dren", 32'(ramREN), 1);
    $display("contention data 0x100 -> dhit=%0b dload=%h", dhit, dload);
    dREN = 0;
    tick();
    ramstate = S_FREE; #1;
    chk("ct_bubble_busy", 32'(busy), 0);
    chk("ct_bubble_hits", 32'({ihit, dhit}), 0);
    tick();
    #1;
    chk("ct_iaddr", ramaddr, 32'h44);
    ramstate = S_ACCESS; ramload = 32'h11111111; #1;
    chk("ct_ihit", 32'(ihit), 1);
    chk("ct_dhit_lo", 32'(dhit), 0);
    chk("ct_iload", iload, 32'h11111111);
    chk("ct_dload_zero", dload, 0);
    $display("contention fetch 0x44 -> ihit=%0b iload=%h", ihit, iload);
    iREN = 0;
    tick();

    // Write
    ramstate = S_FREE; dWEN = 1; daddr = 32'h200; dstore = 32'h12345678; #1;
    tick();
    ramstate = S_BUSY; #1;
    chk("wr_wen", 32'(ramWEN), 1);
    chk("wr_ren", 32'(ramREN), 0);
    chk("wr_store", ramstore, 32'h12345678);
    chk("wr_addr", ramaddr, 32'h200);
    chk("wr_nohit", 32'(dhit), 0);
    tick();
    ramstate = S_ACCESS; #1;
    chk("wr_hit", 32'(dhit), 1);
    chk("wr_hit_wen", 32'(ramWEN), 1);
    $display("write 0x200 <- %h dhit=%0b", ramstore, dhit);
    dWEN = 0;
    tick();
    ramstate = S_FREE; #1;
    chk("wr_after_hit", 32'(dhit), 0);
    chk("wr_after_busy", 32'(busy), 0);

    // Timeout: requester drops after grant; RAM stuck BUSY
    dREN = 1; daddr = 32'h300; ramstate = S_BUSY; #1;
    tick();
    dREN = 0;
    begin
      int early = 0;
      for (int k = 1; k < TIMEOUT; k++) begin
        #1;
        if (dhit !== 1'b0) early++;
        tick();
      end
      chk("to_no_early_hit", 32'(early), 0);
    end
    #1;
    chk("to_hit", 32'(dhit), 1);
    chk("to_load", dload, BAD);
    $display("timeout 0x300 -> dhit=%0b dload=%h", dhit, dload);
    tick();
    ramstate = S_FREE; #1;
    chk("to_merr", 32'(merr), 1);
    chk("to_idle", 32'(busy), 0);
    iREN = 1; iaddr = 32'h48; #1;
    tick();
    ramstate = S_ACCESS; ramload = 32'hCAFEF00D; #1;
    chk("to_good_hit", 32'(ihit), 1);
    chk("to_good_load", iload, 32'hCAFEF00D);
    chk("to_merr_sticky", 32'(merr), 1);
    iREN = 0;
    tick();

    // RAM error on second cycle of a fetch
    ramstate = S_FREE; iREN = 1; iaddr = 32'h4C; #1;
    tick();
    ramstate = S_BUSY; #1;
    chk("er_wait", 32'(ihit), 0);
    tick();
    ramstate = S_ERROR; #1;
    chk("er_hit", 32'(ihit), 1);
    chk("er_load", iload, BAD);
    $display("error fetch 0x4C -> ihit=%0b iload=%h", ihit, iload);
    iREN = 0;
    tick();
    ramstate = S_FREE; #1;
    chk("er_idle", 32'(busy), 0);
    chk("er_merr", 32'(merr), 1);

    // Asynchronous reset during a write
    dWEN = 1; daddr = 32'h500; dstore = 32'hAA; #1;
    tick();
    ramstate = S_BUSY; #1;
    chk("rs_wen_before", 32'(ramWEN), 1);
    #1 nRST = 1'b0;
    #1;
    chk("rs_wen_async", 32'(ramWEN), 0);
    chk("rs_busy_async", 32'(busy), 0);
    dWEN = 0; ramstate = S_FREE;
    tick();
    @(negedge CLK) nRST = 1'b1;
    #1;
    chk("rs_busy", 32'(busy), 0);
    chk("rs_merr", 32'(merr), 0);
    $display("async reset mid-write -> busy=%0b merr=%0b", busy, merr);
    tick();
    iREN = 1; iaddr = 32'h50; #1;
    tick();
    ramstate = S_ACCESS; ramload = 32'h0BADF00D; #1;
    chk("rs_fetch_hit", 32'(ihit), 1);
    chk("rs_fetch_load", iload, 32'h0BADF00D);
    chk("rs_fetch_merr", 32'(merr), 0);
    $display("post-reset fetch 0x50 -> ihit=%0b iload=%h", ihit, iload);
    iREN = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
